// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants: modulus, lane/word geometry, loader state encoding
// and the 6-bit bit-reversal helper used for NTT-ordered addressing.
package dilithium_pkg;

  localparam int unsigned DIL_Q   = 32'd8380417;
  localparam int          LANE_W  = 24;
  localparam int          WORD_W  = 96;
  localparam int          LANES   = WORD_W / LANE_W;
  localparam int          ADDR_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } load_state_e;

  function automatic logic [ADDR_W-1:0] bit_rev6(input logic [ADDR_W-1:0] w);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = w[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/poly_loader.sv
// Packs a stream of 24-bit coefficients into 96-bit BRAM words, natural or bit-reversed order.
// Define POLY_LOADER_SIGNED_EN to accept two's-complement coefficients mapped into [0, Q).
module poly_loader
  import dilithium_pkg::*;
#(
  parameter int unsigned Q      = DIL_Q,
  parameter int unsigned NWORDS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bitrev,
  input  logic                 hold,
  input  logic                 in_valid,
  input  logic [LANE_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [ADDR_W-1:0]    addr,
  output logic                 we,
  output logic [WORD_W-1:0]    di,
  output logic                 done,
  output logic                 err
);

  localparam logic [LANE_W-1:0] Q_L = LANE_W'(Q);

  load_state_e         r_state;
  load_state_e         w_state_next;
  logic [1:0]          r_lane;
  logic [ADDR_W-1:0]   r_word;
  logic                r_bitrev;
  logic [LANE_W-1:0]   r_part [LANES-1];
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [WORD_W-1:0]   r_di;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_lane_last;
  logic                w_word_last;
  logic                w_oor;
  logic [LANE_W-1:0]   w_coef;

  assign in_ready    = (r_state == ST_LOAD) & ~hold & ~rst;
  assign w_accept    = in_valid & in_ready;
  assign w_lane_last = (r_lane == 2'd3);
  assign w_word_last = (r_word == ADDR_W'(NWORDS - 1));

`ifdef POLY_LOADER_SIGNED_EN
  // Lowest accepted negative value is -(Q-1); anything below it is out of range.
  localparam logic [LANE_W-1:0] NEG_MIN = LANE_W'(32'd1 - 32'(Q));
  logic w_neg;
  assign w_neg  = in_data[LANE_W-1];
  assign w_oor  = w_neg ? ($signed(in_data) < $signed(NEG_MIN)) : (in_data >= Q_L);
  assign w_coef = (w_neg && !w_oor) ? (in_data + Q_L) : in_data;
`else
  assign w_oor  = (in_data >= Q_L);
  assign w_coef = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (start) w_state_next = ST_LOAD;
        else if (w_accept && w_lane_last && w_word_last) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_state_next = start ? ST_LOAD : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Lanes 0..2 are buffered; lane 3 goes straight into the output word.
  for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst || start) begin
        r_part[gi] <= '0;
      end else if (w_accept && r_lane == 2'(gi)) begin
        r_part[gi] <= w_coef;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane   <= '0;
      r_word   <= '0;
      r_bitrev <= 1'b0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_di     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (start) begin
        // Restart wins over a same-cycle accept: the partial word is dropped.
        r_lane   <= '0;
        r_word   <= '0;
        r_bitrev <= bitrev;
        r_err    <= 1'b0;
      end else if (w_accept) begin
        r_err  <= r_err | w_oor;
        r_lane <= r_lane + 2'd1;
        if (w_lane_last) begin
          r_we   <= 1'b1;
          r_di   <= {w_coef, r_part[2], r_part[1], r_part[0]};
          r_addr <= r_bitrev ? bit_rev6(r_word) : r_word;
          r_word <= w_word_last ? '0 : r_word + ADDR_W'(1);
          r_done <= w_word_last;
        end
      end
    end
  end

  assign addr = r_addr;
  assign we   = r_we;
  assign di   = r_di;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: doc/poly_loader.md
POLY_LOADER -- requirements
Module: poly_loader

Interface
REQ-001 SHALL have parameter Q, default 8380417, coefficient modulus used for range check and signed mapping.
REQ-002 SHALL have parameter NWORDS, default 64, number of 96-bit BRAM words per polynomial.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a polynomial load.
REQ-006 SHALL have port bitrev  input  1  sampled at start; 1 = 6-bit bit-reversed word addressing, 0 = natural.
REQ-007 SHALL have port hold  input  1  stall request from the operation stage sharing the BRAM (1 = no acceptance).
REQ-008 SHALL have port in_valid  input  1  coefficient valid.
REQ-009 SHALL have port in_data  input  24  coefficient.
REQ-010 SHALL have port in_ready  output  1  coefficient accepted when in_valid & in_ready.
REQ-011 SHALL have port addr  output  6  BRAM write address.
REQ-012 SHALL have port we  output  1  BRAM write enable.
REQ-013 SHALL have port di  output  96  BRAM write data.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of load.
REQ-015 SHALL have port err  output  1  sticky out-of-range flag, cleared by start.

Function
REQ-016 SHALL implement states IDLE, LOAD, FLUSH; IDLE->LOAD on start; LOAD->FLUSH on the 4*NWORDS-th accept; FLUSH->IDLE after one cycle.
REQ-017 in_ready SHALL equal (state==LOAD) & ~hold & ~rst, combinationally.
REQ-018 Accepted coefficient k of a word (k=0..3) SHALL be placed in di[24k+23:24k]; lane counter wraps 3->0.
REQ-019 On the accept of lane 3, the registered outputs SHALL assert we=1 with the packed word on the next cycle, for exactly one cycle; we=0 at all other times.
REQ-020 Word counter w (0..NWORDS-1) SHALL increment on each lane-3 accept; addr = w when bitrev=0, addr = bit-reverse(w[5:0]) when bitrev=1.
REQ-021 done SHALL pulse in the FLUSH cycle, i.e. the same cycle as the final we; counters return to 0.
REQ-022 Unsigned mode: in_data >= Q SHALL set err; coefficient stored unchanged.
REQ-023 start in LOAD or FLUSH SHALL restart: counters and partial word cleared, err cleared, bitrev resampled; no write for the discarded partial word; no done.
REQ-024 hold asserted mid-word SHALL stall only; partial lanes retained, no write emitted.
REQ-025 in_valid outside LOAD SHALL be ignored.

Reset
REQ-026 rst SHALL force state IDLE, lane/word counters 0, addr=0, we=0, di=0, done=0, err=0, in_ready=0; partial word discarded; rst dominates start.

Configuration
REQ-027 With POLY_LOADER_SIGNED_EN defined, in_data SHALL be two's complement: values in [-(Q-1),-1] stored as in_data+Q; values < -(Q-1) or >= Q set err and are stored unchanged.
REQ-028 Without POLY_LOADER_SIGNED_EN, unsigned behaviour of REQ-022 SHALL apply and no adder SHALL be synthesised.

Structure
REQ-029 Q, lane width 24, word width 96 and the state encoding SHALL live in the shared dilithium package.
REQ-030 Bit-reversal SHALL be a function in the package; no sub-module is required.

Verification
REQ-031 Natural load: start, bitrev=0, stream 0..255 without gaps -> 64 writes, addr 0..63, word 0 di=0x000003_000002_000001_000000, done with the last write.
REQ-032 Bit-reversed load: bitrev=1 -> 2nd write addr=32, 3rd write addr=16, last write addr=63.
REQ-033 Backpressure: hold=1 for 5 cycles after lane 1 of word 7 -> in_ready=0, no we; resumes and word 7 is packed correctly.
REQ-034 Range: coefficient 8380417 at index 10 -> err=1 until next start; stored value unchanged; signed build with -1 -> stored 8380416, err=0.
REQ-035 Restart/reset: start after 130 accepts -> no write for the partial word, next write addr=0, no done; rst mid-load -> all outputs 0, IDLE.
